// File: rtl/clb_cfg_loader.sv
// Serial bitstream loader for a clb42 array: sync byte, frame count, per-CLB frames.
// Optional CLB_CFG_PARITY_EN appends an even-parity bit to every frame.
module clb_cfg_loader #(
  parameter int NUM_CLB = 4,
  parameter int CFG_W   = 37,
  parameter int ADDR_W  = 2
) (
  input  logic              K,
  input  logic              RST,
  input  logic              PROG,
  input  logic              DIN,
  input  logic              DVALID,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic              CFG_WE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

`ifdef CLB_CFG_PARITY_EN
  localparam int FRM_BITS = CFG_W + 1;
`else
  localparam int FRM_BITS = CFG_W;
`endif
  localparam int CNT_RAW = $clog2(FRM_BITS + 1);
  localparam int CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRM_BITS - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       SYNC_B   = 8'hA5;
  localparam logic [7:0]       MAX_N    = 8'(NUM_CLB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR,
    S_FRAME,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          win_q, win_d;
  logic [7:0]          hdr_q, hdr_d;
  logic [7:0]          nfr_q, nfr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CFG_W-1:0]    sh_q, sh_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CFG_W-1:0]    data_q, data_d;
  logic                commit;
  logic [CFG_W-1:0]    frame;

  always_ff @(posedge K) begin
    if (RST) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      hdr_q   <= '0;
      nfr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      hdr_q   <= hdr_d;
      nfr_q   <= nfr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hdr_d   = hdr_q;
    nfr_d   = nfr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    commit  = 1'b0;
    frame   = '0;

    if (PROG) begin
      state_d = S_SYNC;
      win_d   = '0;
      hdr_d   = '0;
      nfr_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
      sh_d    = '0;
      addr_d  = '0;
    end else if (DVALID) begin
      unique case (state_q)
        S_SYNC: begin
          win_d = {win_q[6:0], DIN};
          if (win_d == SYNC_B) begin
            state_d = S_HDR;
            cnt_d   = '0;
          end
        end
        S_HDR: begin
          hdr_d = {hdr_q[6:0], DIN};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            nfr_d = hdr_d;
            idx_d = '0;
            if (hdr_d == 8'd0 || hdr_d > MAX_N)
              state_d = S_ERROR;
            else
              state_d = S_FRAME;
          end
        end
        S_FRAME: begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef CLB_CFG_PARITY_EN
          if (cnt_q != LAST) begin
            sh_d = {sh_q[CFG_W-2:0], DIN};
          end else begin
            cnt_d = '0;
            // even parity: payload XOR parity bit must be zero
            if (DIN == ^sh_q) begin
              commit = 1'b1;
              frame  = sh_q;
            end else begin
              state_d = S_ERROR;
              addr_d  = idx_q;
            end
          end
`else
          sh_d = {sh_q[CFG_W-2:0], DIN};
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            commit = 1'b1;
            frame  = sh_d;
          end
`endif
        end
        default: ;
      endcase

      // write strobe is registered, so it appears the cycle after the last bit
      if (commit) begin
        we_d   = 1'b1;
        addr_d = idx_q;
        data_d = frame;
        idx_d  = idx_q + ADDR_W'(1);
        if (8'(idx_q) == nfr_q - 8'd1)
          state_d = S_DONE;
      end
    end
  end

  assign CFG_WE   = we_q;
  assign CFG_ADDR = addr_q;
  assign CFG_DATA = data_q;
  assign BUSY     = (state_q == S_SYNC) ||
                    (state_q == S_HDR)  ||
                    (state_q == S_FRAME);
  assign DONE     = (state_q == S_DONE);
  assign ERR      = (state_q == S_ERROR);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: directed and random bitstreams scored against
// a stream-level parser model.
module tb_clb_cfg_loader;

  localparam int NUM_CLB = 4;
  localparam int CFG_W   = 37;
  localparam int ADDR_W  = 2;
`ifdef CLB_CFG_PARITY_EN
  localparam int FW = CFG_W + 1;
`else
  localparam int FW = CFG_W;
`endif

  logic              K = 1'b0;
  logic              RST = 1'b1;
  logic              PROG = 1'b0;
  logic              DIN = 1'b0;
  logic              DVALID = 1'b0;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic [CFG_W-1:0]  CFG_DATA;
  logic              CFG_WE;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  clb_cfg_loader #(
    .NUM_CLB(NUM_CLB),
    .CFG_W  (CFG_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .K       (K),
    .RST     (RST),
    .PROG    (PROG),
    .DIN     (DIN),
    .DVALID  (DVALID),
    .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA),
    .CFG_WE  (CFG_WE),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 K = ~K;

  int total = 0;
  int bad = 0;

  bit               stream[$];
  int               obs_addr[$];
  logic [CFG_W-1:0] obs_data[$];
  bit               obs_done[$];
  int               exp_addr[$];
  logic [CFG_W-1:0] exp_data[$];
  bit               exp_done, exp_err, exp_busy;
  int               exp_fin_addr;

  always @(negedge K) begin
    if (CFG_WE === 1'b1) begin
      obs_addr.push_back(int'(CFG_ADDR));
      obs_data.push_back(CFG_DATA);
      obs_done.push_back(DONE);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge K);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endtask

  task automatic push_frame(input logic [CFG_W-1:0] d, input bit flip);
    for (int i = CFG_W - 1; i >= 0; i--) stream.push_back(d[i]);
`ifdef CLB_CFG_PARITY_EN
    stream.push_back((^d) ^ flip);
`else
    if (flip) stream.push_back(1'b0);
    if (flip) void'(stream.pop_back());
`endif
  endtask

  function automatic logic [CFG_W-1:0] rnd_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CFG_W-1:0];
  endfunction

  // Parse the whole stream the way the loader is meant to interpret it.
  task automatic model();
    int pos;
    int n;
    int p;
    logic [7:0] w;
    logic [CFG_W-1:0] d;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    exp_busy = 1;
    exp_fin_addr = 0;
    pos = -1;
    w = 8'h00;
    for (int i = 0; i < stream.size(); i++) begin
      w = {w[6:0], stream[i]};
      if (w == 8'hA5) begin
        pos = i;
        break;
      end
    end
    if (pos < 0 || pos + 8 >= stream.size()) return;
    n = 0;
    for (int k = 1; k <= 8; k++) n = n * 2 + int'(stream[pos+k]);
    if (n == 0 || n > NUM_CLB) begin
      exp_err = 1;
      exp_busy = 0;
      return;
    end
    p = pos + 9;
    for (int f = 0; f < n; f++) begin
      if (p + FW > stream.size()) return;
      d = '0;
      for (int k = 0; k < CFG_W; k++) d[CFG_W-1-k] = stream[p+k];
`ifdef CLB_CFG_PARITY_EN
      if ((^d) != stream[p+CFG_W]) begin
        exp_err = 1;
        exp_busy = 0;
        exp_fin_addr = f;
        return;
      end
`endif
      exp_addr.push_back(f);
      exp_data.push_back(d);
      exp_fin_addr = f;
      p += FW;
    end
    exp_done = 1;
    exp_busy = 0;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_done.delete();
  endtask

  task automatic prog_pulse();
    PROG = 1'b1;
    DVALID = 1'b1;
    DIN = 1'($urandom_range(0, 1));
    step();
    PROG = 1'b0;
    DVALID = 1'b0;
  endtask

  // mode 0: DVALID always, 1: toggling 1/0, 2: random gaps
  task automatic send(input int mode);
    bit tog;
    bit dv;
    int gap;
    tog = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      gap = 0;
      forever begin
        if (mode == 0) dv = 1'b1;
        else if (mode == 1) begin
          dv = tog;
          tog = ~tog;
        end else dv = (gap >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        DVALID = dv;
        DIN = dv ? stream[i] : 1'($urandom_range(0, 1));
        step();
        gap++;
        if (dv) break;
      end
    end
    DVALID = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_result(input string tag);
    int ne;
    ne = exp_addr.size();
    chk({tag, "_nwr"}, 64'(obs_addr.size()), 64'(ne));
    for (int i = 0; i < ne && i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
    end
    if (exp_done && obs_done.size() > 0)
      chk({tag, "_done_at_we"}, 64'(obs_done[obs_done.size()-1]), 64'(1));
    chk({tag, "_err"}, 64'(ERR), 64'(exp_err));
    chk({tag, "_done"}, 64'(DONE), 64'(exp_done));
    chk({tag, "_busy"}, 64'(BUSY), 64'(exp_busy));
    chk({tag, "_fin_addr"}, 64'(CFG_ADDR), 64'(exp_fin_addr));
    if (ne > 0)
      chk({tag, "_fin_data"}, 64'(CFG_DATA), 64'(exp_data[ne-1]));
  endtask

  task automatic run(input string tag, input int mode);
    clear_obs();
    prog_pulse();
    send(mode);
    model();
    check_result(tag);
  endtask

  task automatic build_basic(input bit flip1);
    stream.delete();
    push_byte(8'hA5);
    push_byte(8'd2);
    push_frame(37'h00_0000_0116, 1'b0);
    push_frame(37'h1F_FFFF_FFFF, flip1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 64'(CFG_WE), 64'(0));
    chk({tag, "_addr"}, 64'(CFG_ADDR), 64'(0));
    chk({tag, "_data"}, 64'(CFG_DATA), 64'(0));
    chk({tag, "_busy"}, 64'(BUSY), 64'(0));
    chk({tag, "_done"}, 64'(DONE), 64'(0));
    chk({tag, "_err"}, 64'(ERR), 64'(0));
  endtask

  initial begin
    int n;
    int pre;

    RST = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    RST = 1'b0;
    step();
    check_all_zero("idle");

    build_basic(1'b0);
    run("basic", 0);
    chk("basic_first_data", 64'(obs_data.size() > 0 ? obs_data[0] : '0),
        64'(37'h00_0000_0116));

    build_basic(1'b0);
    run("toggle", 1);

    stream.delete();
    push_byte(8'h5A);
    push_byte(8'hA4);
    push_byte(8'hA5);
    push_byte(8'd1);
    push_frame(rnd_frame(), 1'b0);
    run("noise", 0);

    stream.delete();
    push_byte(8'hA5);
    push_byte(8'd0);
    push_frame(rnd_frame(), 1'b0);
    run("n_zero", 0);
    build_basic(1'b0);
    run("after_nzero", 0);

    stream.delete();
    push_byte(8'hA5);
    push_byte(8'd5);
    for (int i = 0; i < 5; i++) push_frame(rnd_frame(), 1'b0);
    run("n_five", 2);
    build_basic(1'b0);
    run("after_nfive", 2);

    // abort by PROG partway through frame 1
    build_basic(1'b0);
    for (int i = 0; i < 20; i++) void'(stream.pop_back());
    run("prog_partial", 0);
    build_basic(1'b0);
    run("prog_reload", 0);

    // abort by RST partway through frame 1
    build_basic(1'b0);
    for (int i = 0; i < 20; i++) void'(stream.pop_back());
    run("rst_partial", 0);
    clear_obs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      DVALID = 1'b1;
      DIN = 1'($urandom_range(0, 1));
      step();
    end
    DVALID = 1'b0;
    step();
    chk("rst_no_we", 64'(obs_addr.size()), 64'(0));
    check_all_zero("rst_outs");
    build_basic(1'b0);
    run("rst_reload", 0);

`ifdef CLB_CFG_PARITY_EN
    build_basic(1'b1);
    run("par_bad", 0);
    chk("par_err", 64'(ERR), 64'(1));
    chk("par_addr", 64'(CFG_ADDR), 64'(1));
`endif

    for (int it = 0; it < 8; it++) begin
      stream.delete();
      pre = $urandom_range(0, 12);
      for (int i = 0; i < pre; i++) stream.push_back(1'($urandom_range(0, 1)));
      push_byte(8'hA5);
      n = $urandom_range(0, NUM_CLB + 2);
      push_byte(8'(n));
      for (int f = 0; f < n; f++)
        push_frame(rnd_frame(), ($urandom_range(0, 5) == 0));
      run("rand", $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
